// File: rtl/multi_cycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I datapath: walks each instruction
// through IF/ID/EX/MEM/WB/BR, decodes datapath selects and counts retirements.
module multi_cycle_control_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        alu_bcond,
  input  logic        halt_cond,
  output logic        pc_write,
  output logic        pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        is_ecall,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  localparam logic [2:0] StIf   = 3'd0;
  localparam logic [2:0] StId   = 3'd1;
  localparam logic [2:0] StEx   = 3'd2;
  localparam logic [2:0] StMem  = 3'd3;
  localparam logic [2:0] StWb   = 3'd4;
  localparam logic [2:0] StBr   = 3'd5;
  localparam logic [2:0] StHalt = 3'd6;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [2:0]  state_q, state_d;
  logic [31:0] retired_q;

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    is_ecall   = 1'b0;
    halted     = 1'b0;
    // Outputs are forced low for the whole time reset is held.
    if (!reset_n) begin
      state_d = StIf;
    end else begin
      case (state_q)
        StIf: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = StId;
          end
        end
        StId: begin
          alu_src_b = 2'b01;
          state_d   = StEx;
          if (opcode == OpSystem) begin
            is_ecall = 1'b1;
            if (halt_cond) state_d = StHalt;
          end
        end
        StEx: begin
          alu_src_a = 1'b1;
          case (opcode)
            OpR: begin
              alu_op  = 2'b10;
              state_d = StWb;
            end
            OpI: begin
              alu_src_b = 2'b10;
              alu_op    = 2'b11;
              state_d   = StWb;
            end
            OpLoad, OpStore: begin
              alu_src_b = 2'b10;
              state_d   = StMem;
            end
            OpBranch: begin
              alu_op = 2'b01;
              if (alu_bcond) begin
                state_d = StBr;
              end else begin
                pc_write  = 1'b1;
                pc_source = 1'b1;
                state_d   = StIf;
              end
            end
            OpJal, OpJalr: begin
              alu_src_a = (opcode == OpJalr);
              alu_src_b = 2'b10;
              reg_write = 1'b1;
              pc_write  = 1'b1;
              state_d   = StIf;
            end
            default: begin
              alu_src_a = 1'b0;
              alu_src_b = 2'b01;
              pc_write  = 1'b1;
              state_d   = StIf;
            end
          endcase
        end
        StMem: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OpLoad);
          mem_write = (opcode != OpLoad);
          if (mem_ready) begin
            if (opcode == OpLoad) begin
              mdr_write = 1'b1;
              state_d   = StWb;
            end else begin
              alu_src_b = 2'b01;
              pc_write  = 1'b1;
              state_d   = StIf;
            end
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OpLoad);
          alu_src_b  = 2'b01;
          pc_write   = 1'b1;
          state_d    = StIf;
        end
        StBr: begin
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          state_d   = StIf;
        end
        StHalt: begin
          halted = 1'b1;
        end
        default: state_d = StIf;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIf;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (pc_write) retired_q <= retired_q + 32'd1;
    end
  end

  assign state         = state_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Directed bench: per-cycle expected state/strobes/retire count are queued per
// instruction, then replayed against the controller cycle by cycle.
module tb_multi_cycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        alu_bcond = 1'b0;
  logic        halt_cond = 1'b0;
  logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic        reg_write, mem_to_reg, alu_src_a, is_ecall, halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  state;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  multi_cycle_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .alu_bcond(alu_bcond), .halt_cond(halt_cond), .pc_write(pc_write),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .is_ecall(is_ecall), .halted(halted), .state(state),
    .retired_count(retired_count)
  );

  // Bit layout of the packed strobe vector.
  localparam logic [15:0] PCW = 16'h8000, PCS = 16'h4000, IOD = 16'h2000, MR = 16'h1000;
  localparam logic [15:0] MW = 16'h0800, IRW = 16'h0400, MDRW = 16'h0200, RW = 16'h0100;
  localparam logic [15:0] M2R = 16'h0080, SA = 16'h0040, SB4 = 16'h0010, SBI = 16'h0020;
  localparam logic [15:0] OPBR = 16'h0004, OPR = 16'h0008, OPI = 16'h000C;
  localparam logic [15:0] EC = 16'h0002, HLT = 16'h0001;

  localparam logic [6:0] OpR = 7'b0110011, OpI = 7'b0010011, OpLd = 7'b0000011;
  localparam logic [6:0] OpSt = 7'b0100011, OpBr = 7'b1100011, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpSys = 7'b1110011, OpLui = 7'b0110111;

  logic [15:0] obs_sig;
  assign obs_sig = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write,
                    reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, is_ecall, halted};

  typedef struct {
    string       tag;
    logic [6:0]  op;
    logic [2:0]  st;
    logic [15:0] sig;
    logic [31:0] ret;
    logic        rdy;
    logic        bc;
    logic        hc;
  } item_t;

  item_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [6:0] op, input logic [2:0] st,
                      input logic [15:0] sig, input logic rdy, input logic bc, input logic hc);
    item_t it;
    it.tag = tag; it.op = op; it.st = st; it.sig = sig;
    it.rdy = rdy; it.bc = bc; it.hc = hc; it.ret = exp_ret;
    sb_q.push_back(it);
    if ((sig & PCW) != 16'h0) exp_ret = exp_ret + 32'd1;
  endtask

  // Called at posedge+1; drives one queued cycle, compares at the falling edge.
  task automatic drain();
    item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      opcode = it.op; mem_ready = it.rdy; alu_bcond = it.bc; halt_cond = it.hc;
      #4;
      check({it.tag, "_state"}, {29'd0, state}, {29'd0, it.st});
      check({it.tag, "_sig"}, {16'd0, obs_sig}, {16'd0, it.sig});
      check({it.tag, "_retired"}, retired_count, it.ret);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] op, input int waits,
                              input logic ecall, input logic hc);
    for (int i = 0; i < waits; i++) push({tag, "_ifw"}, op, 3'd0, MR, 1'b0, 1'b0, 1'b0);
    push({tag, "_if"}, op, 3'd0, MR | IRW, 1'b1, 1'b0, 1'b0);
    push({tag, "_id"}, op, 3'd1, ecall ? (SB4 | EC) : SB4, 1'b0, 1'b1, hc);
  endtask

  initial begin
    mem_ready = 1'b1;
    opcode = OpR;
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_sig", {16'd0, obs_sig}, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    fetch_decode("r", OpR, 0, 1'b0, 1'b0);
    push("r_ex", OpR, 3'd2, SA | OPR, 1'b1, 1'b0, 1'b0);
    push("r_wb", OpR, 3'd4, RW | SB4 | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("i", OpI, 0, 1'b0, 1'b0);
    push("i_ex", OpI, 3'd2, SA | SBI | OPI, 1'b0, 1'b0, 1'b0);
    push("i_wb", OpI, 3'd4, RW | SB4 | PCW, 1'b0, 1'b0, 1'b0);
    fetch_decode("ld", OpLd, 0, 1'b0, 1'b0);
    push("ld_ex", OpLd, 3'd2, SA | SBI, 1'b1, 1'b0, 1'b0);
    push("ld_memw", OpLd, 3'd3, IOD | MR, 1'b0, 1'b0, 1'b0);
    push("ld_memw", OpLd, 3'd3, IOD | MR, 1'b0, 1'b0, 1'b0);
    push("ld_mem", OpLd, 3'd3, IOD | MR | MDRW, 1'b1, 1'b0, 1'b0);
    push("ld_wb", OpLd, 3'd4, RW | M2R | SB4 | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("st", OpSt, 1, 1'b0, 1'b0);
    push("st_ex", OpSt, 3'd2, SA | SBI, 1'b1, 1'b0, 1'b0);
    push("st_mem", OpSt, 3'd3, IOD | MW | SB4 | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("bnt", OpBr, 0, 1'b0, 1'b0);
    push("bnt_ex", OpBr, 3'd2, SA | OPBR | PCW | PCS, 1'b1, 1'b0, 1'b0);
    fetch_decode("bt", OpBr, 0, 1'b0, 1'b0);
    push("bt_ex", OpBr, 3'd2, SA | OPBR, 1'b1, 1'b1, 1'b0);
    push("bt_br", OpBr, 3'd5, SBI | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("jal", OpJal, 0, 1'b0, 1'b0);
    push("jal_ex", OpJal, 3'd2, RW | SBI | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("jalr", OpJalr, 0, 1'b0, 1'b0);
    push("jalr_ex", OpJalr, 3'd2, RW | SA | SBI | PCW, 1'b0, 1'b0, 1'b0);
    fetch_decode("lui", OpLui, 0, 1'b0, 1'b0);
    push("lui_ex", OpLui, 3'd2, SB4 | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("ecall", OpSys, 0, 1'b1, 1'b0);
    push("ecall_ex", OpSys, 3'd2, SB4 | PCW, 1'b1, 1'b0, 1'b0);
    // A store left stalled in MEM, to be cut off by reset.
    fetch_decode("stx", OpSt, 0, 1'b0, 1'b0);
    push("stx_ex", OpSt, 3'd2, SA | SBI, 1'b1, 1'b0, 1'b0);
    push("stx_memw", OpSt, 3'd3, IOD | MW, 1'b0, 1'b0, 1'b0);
    push("stx_memw", OpSt, 3'd3, IOD | MW, 1'b0, 1'b0, 1'b0);
    drain();

    mem_ready = 1'b0;
    #2;
    check("midmem_state", {29'd0, state}, 32'd3);
    check("midmem_retired", retired_count, 32'd10);
    reset_n = 1'b0;
    #1;
    check("rstmem_state", {29'd0, state}, 32'd0);
    check("rstmem_sig", {16'd0, obs_sig}, 32'd0);
    check("rstmem_retired", retired_count, 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    check("rstheld_sig", {16'd0, obs_sig}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_ret = 32'd0;

    fetch_decode("r2", OpR, 0, 1'b0, 1'b0);
    push("r2_ex", OpR, 3'd2, SA | OPR, 1'b1, 1'b0, 1'b0);
    push("r2_wb", OpR, 3'd4, RW | SB4 | PCW, 1'b1, 1'b0, 1'b0);
    fetch_decode("halt", OpSys, 0, 1'b1, 1'b1);
    push("halt_0", OpSys, 3'd6, HLT, 1'b1, 1'b1, 1'b1);
    push("halt_1", OpR, 3'd6, HLT, 1'b0, 1'b0, 1'b0);
    push("halt_2", OpJal, 3'd6, HLT, 1'b1, 1'b0, 1'b0);
    push("halt_3", OpSt, 3'd6, HLT, 1'b1, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
